mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mem_extend.sv | 21 ++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: memControl size/sign codes, FSM states and access-size helper shared with the ID-stage decoder
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        MC_NONE    = 3'd0,
        MC_BYTE    = 3'd1,
        MC_HALF    = 3'd2,
        MC_WORD    = 3'd3,
        MC_DWORD   = 3'd4,
        MC_BYTE_U  = 3'd5,
        MC_HALF_U  = 3'd6,
        MC_WORD_U  = 3'd7
    } mem_ctl_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT1 = 2'd1,
        S_BEAT2 = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    function automatic logic [3:0] size_of(input logic [2:0] code);
        return (code == MC_BYTE || code == MC_BYTE_U) ? 4'd1 :
               (code == MC_HALF || code == MC_HALF_U) ? 4'd2 :
               (code == MC_DWORD) ? 4'd8 : 4'd4;
    endfunction

endpackage

// File: rtl/mem_extend.sv
// mem_extend: sign/zero extension of right-justified load data by memControl code (ctl, data -> result)
module mem_extend
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      ctl,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = (ctl == MC_BYTE)   ? {{(XLEN-8){data[7]}}, data[7:0]} :
                 (ctl == MC_HALF)   ? {{(XLEN-16){data[15]}}, data[15:0]} :
                 (ctl == MC_WORD)   ? {{(XLEN-32){data[31]}}, data[31:0]} :
                 (ctl == MC_BYTE_U) ? {{(XLEN-8){1'b0}}, data[7:0]} :
                 (ctl == MC_HALF_U) ? {{(XLEN-16){1'b0}}, data[15:0]} :
                 (ctl == MC_WORD_U) ? {{(XLEN-32){1'b0}}, data[31:0]} : data;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: unaligned load/store sequencer onto an 8-byte aligned bus (pipeline start/busy/done/rdata, bus mem_req/we/addr/be/wdata/ack/rdata)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      memControl,
    input  logic            is_store,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [XLEN-1:0] BEAT_STRIDE = 8;

    state_e          state;
    logic [2:0]      ctl_r;
    logic [2:0]      off_r;
    logic            st_r;
    logic [7:0]      be_hi;
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] lo_r;
    logic [3:0]      size;
    logic [15:0]     mask;
    logic [5:0]      sh_in;
    logic [5:0]      sh_lo;
    logic [5:0]      sh_hi;
    logic [XLEN-1:0] beat_lo;
    logic [XLEN-1:0] ext_in;
    logic [XLEN-1:0] ext_out;

    always_comb begin
        size    = size_of(memControl);
        mask    = ((16'd1 << size) - 16'd1) << addr[2:0];
        sh_in   = {addr[2:0], 3'b000};
        sh_lo   = {off_r, 3'b000};
        sh_hi   = {3'(3'd0 - off_r), 3'b000};
        beat_lo = mem_rdata >> sh_lo;
        ext_in  = (state == S_BEAT2) ? (lo_r | (mem_rdata << sh_hi)) : beat_lo;
    end

    assign busy = (state != S_IDLE);

    mem_extend #(.XLEN(XLEN)) u_extend (
        .ctl    (ctl_r),
        .data   (ext_in),
        .result (ext_out)
    );

    // A non-zero upper mask byte means the access spills into the next aligned word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ctl_r     <= '0;
            off_r     <= '0;
            st_r      <= 1'b0;
            be_hi     <= '0;
            wdata_r   <= '0;
            lo_r      <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && memControl != MC_NONE) begin
                        ctl_r     <= memControl;
                        off_r     <= addr[2:0];
                        st_r      <= is_store;
                        wdata_r   <= wdata;
                        be_hi     <= mask[15:8];
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {addr[XLEN-1:3], 3'b000};
                        mem_be    <= mask[7:0];
                        mem_wdata <= wdata << sh_in;
                        state     <= S_BEAT1;
                    end
                end
                S_BEAT1: begin
                    if (mem_ack) begin
                        lo_r <= beat_lo;
                        if (|be_hi) begin
                            mem_addr  <= mem_addr + BEAT_STRIDE;
                            mem_be    <= be_hi;
                            mem_wdata <= wdata_r >> sh_hi;
                            state     <= S_BEAT2;
                        end else begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            rdata   <= st_r ? '0 : ext_out;
                            done    <= 1'b1;
                            state   <= S_RESP;
                        end
                    end
                end
                S_BEAT2: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        rdata   <= st_r ? '0 : ext_out;
                        done    <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
